// File: rtl/multdiv_pkg.sv
// Shared state and opcode encodings for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} multdiv_state_t;
    typedef enum logic {OP_MUL, OP_DIV} multdiv_op_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide on a {hi,lo} pair.
module muldiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  multdiv_op_t      op,
    input  logic [WIDTH-1:0] part_hi,
    input  logic [WIDTH-1:0] part_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;
    logic           unused_diff_msb;

    always_comb begin
        mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
        div_shift = {part_hi, part_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_ge    = (div_shift >= {1'b0, operand});

        if (op == OP_MUL) begin
            // The adder carry becomes the new top bit as the pair shifts right.
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], part_lo[WIDTH-1:1]};
        end else begin
            next_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            next_lo = {part_lo[WIDTH-2:0], div_ge};
        end
    end

    // The remainder always stays below the divisor, so the difference never needs its top bit.
    assign unused_diff_msb = div_diff[WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide with HI/LO result registers and start/busy/done handshake; WIDTH+2 cycle latency.
// Define MULTDIV_SIGNED_EN to honour sgn (magnitude capture plus sign correction in FIX).
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    multdiv_state_t   state, state_nxt;
    multdiv_op_t      op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] w_hi, w_lo, w_opd;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic             accept, zero_div;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign zero_div = accept && op && (b == '0);
    assign busy     = (state == CALC) || (state == FIX);
    assign done     = (state == DONE);

`ifdef MULTDIV_SIGNED_EN
    logic neg_a, neg_b;
    logic neg_q, neg_rem_q;
    logic [2*WIDTH-1:0] fix_prod;

    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept && !zero_div) begin
            neg_q     <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
        end
    end

    // The product is negated as one 2W value so the borrow crosses from lo into hi.
    always_comb begin
        fix_prod = {w_hi, w_lo};
        fix_hi   = w_hi;
        fix_lo   = w_lo;
        if (op_q == OP_MUL) begin
            if (neg_q) begin
                fix_prod = -{w_hi, w_lo};
            end
            fix_hi = fix_prod[2*WIDTH-1:WIDTH];
            fix_lo = fix_prod[WIDTH-1:0];
        end else begin
            fix_lo = neg_q ? -w_lo : w_lo;
            fix_hi = neg_rem_q ? -w_hi : w_hi;
        end
    end
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign mag_a      = a;
    assign mag_b      = b;
    assign fix_hi     = w_hi;
    assign fix_lo     = w_lo;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .part_hi (w_hi),
        .part_lo (w_lo),
        .operand (w_opd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = zero_div ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: both ops start from {0, a} with b as the per-step operand.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q  <= OP_MUL;
            cnt   <= '0;
            w_hi  <= '0;
            w_lo  <= '0;
            w_opd <= '0;
        end else if (accept && !zero_div) begin
            op_q  <= op ? OP_DIV : OP_MUL;
            cnt   <= CNT_W'(WIDTH);
            w_hi  <= '0;
            w_lo  <= mag_a;
            w_opd <= mag_b;
        end else if (state == CALC) begin
            w_hi <= step_hi;
            w_lo <= step_lo;
            cnt  <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (zero_div) begin
            hi       <= a;
            lo       <= '1;
            div_zero <= 1'b1;
        end else if (state == FIX) begin
            hi       <= fix_hi;
            lo       <= fix_lo;
            div_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32) with a cycle-level behavioural model and literal checks.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MULTDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic         sgn   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: 64-bit integer math on the operands as the sgn flag interprets them.
    function automatic void model_calc(input bit o, input bit s, input logic [W-1:0] av,
                                       input logic [W-1:0] bv, output logic [W-1:0] rh,
                                       output logic [W-1:0] rl, output bit dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        bit se;
        se = s && SIGNED_BUILD;
        sa = se ? longint'(signed'(av)) : longint'({32'b0, av});
        sb = se ? longint'(signed'(bv)) : longint'({32'b0, bv});
        dz = 1'b0;
        if (o && bv == '0) begin
            rh = av;
            rl = '1;
            dz = 1'b1;
        end else if (!o) begin
            p  = 64'(sa * sb);
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rl = q[31:0];
            rh = r[31:0];
        end
    endfunction

    // Timeline model: an accepted op completes W+1 edges later, a zero divide at once.
    int           remain = -1;
    bit           m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; remain = -1;
        end else begin
            m_done = 1'b0;
            if (remain < 0) begin
                if (start) begin
                    model_calc(op, sgn, a, b, p_hi, p_lo, p_dz);
                    if (op && b == '0) begin
                        m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
                    end else begin
                        remain = W + 1;
                        m_busy = 1'b1;
                    end
                end
            end else begin
                remain--;
                if (remain == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                    m_done = 1'b1; m_busy = 1'b0; remain = -1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("model_busy", busy, m_busy);
            check("model_done", done, m_done);
            check("model_div_zero", div_zero, m_dz);
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    // Returns the number of cycles from the sampling edge until done is seen (1 = cycle right after).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!done && cyc < 200);
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input bit now, input bit o, input bit s, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output int cyc);
        if (!now) @(negedge clock);
        start = 1'b1; op = o; sgn = s; a = av; b = bv;
        @(posedge clock);
        cyc = 0;
        do begin
            @(negedge clock);
            if (cyc == 0) begin
                start = 1'b0;
                a = $urandom; b = $urandom; op = 1'($urandom); sgn = 1'($urandom);
            end
            cyc++;
        end while (!done && cyc < 200);
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cyc;
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("t1_latency", cyc, 34);
        check("t1_hi", hi, 32'hFFFFFFFE);
        check("t1_lo", lo, 32'h00000001);

        run_op(1'b0, 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, cyc);
        check("t2_hi", hi, SIGNED_BUILD ? 32'hFFFFFFFF : 32'h00000006);
        check("t2_lo", lo, 32'hFFFFFFEB);

        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, cyc);
        check("t3_lo", lo, 32'd14);
        check("t3_hi", hi, 32'd2);
        check("t3_latency", cyc, 34);

        run_op(1'b0, 1'b1, 1'b1, 32'hFFFFFF9C, 32'd7, cyc);
        check("t3b_lo", lo, SIGNED_BUILD ? 32'hFFFFFFF2 : 32'h24924916);
        check("t3b_hi", hi, SIGNED_BUILD ? 32'hFFFFFFFE : 32'h00000002);

        run_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
        check("minneg1_lo", lo, SIGNED_BUILD ? 32'h80000000 : 32'h00000000);
        check("minneg1_hi", hi, SIGNED_BUILD ? 32'h00000000 : 32'h80000000);
        check("minneg1_div_zero", div_zero, 1'b0);

        run_op(1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, cyc);
        check("t4_latency", cyc, 1);
        check("t4_div_zero", div_zero, 1'b1);
        check("t4_lo", lo, 32'hFFFFFFFF);
        check("t4_hi", hi, 32'h1234);
        @(negedge clock);
        check("t4_dz_held", div_zero, 1'b1);
        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, cyc);
        check("t4_dz_cleared", div_zero, 1'b0);

        // Reset in the middle of a multiply.
        @(negedge clock);
        start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'hFFFFFFFF; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_hi", hi, 32'h0);
        check("t5_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_op(1'b0, 1'b0, 1'b0, 32'd6, 32'd7, cyc);
        check("t5_lo42", lo, 32'd42);
        check("t5_hi0", hi, 32'd0);

        // A start (even a zero divide) arriving while busy must be ignored.
        @(negedge clock);
        start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'd11; b = 32'd13;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
        check("t6_ignored_lo", lo, 32'd143);
        check("t6_ignored_hi", hi, 32'd0);
        check("t6_ignored_dz", div_zero, 1'b0);

        // Back-to-back: start issued in the done cycle.
        run_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        check("t6_b2b_latency", cyc, 34);
        check("t6_b2b_hi", hi, 32'hFFFFFFFE);
        check("t6_b2b_lo", lo, 32'h00000001);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
